prio_readout_n: RTL and testbench
=================================

PRIO_READOUT_N -- requirements
Module: prio_readout_n

Interface
REQ-001 Parameter NCH, default 4, number of memory channels (legal range 2..16).
REQ-002 Parameter AW, default 6, per-channel address and item-count width.
REQ-003 Localparam CHW = max(1, clog2(NCH)), width of the channel index.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 initial_count  in  NCH*AW  item count per channel; channel i occupies bits [i*AW +: AW].
REQ-007 init  in  1  one-cycle pulse; loads all counts and starts a new crossing.
REQ-008 setup  in  1  multi-cycle hold-off; while high, no grant occurs.
REQ-009 enable  in  1  global run permission.
REQ-010 ready  in  1  downstream accepts a read this cycle.
REQ-011 addr  out  AW  memory address (low bits) of the granted item.
REQ-012 chan  out  CHW  index of the granted channel.
REQ-013 valid  out  1  memory data for addr/chan is being read this cycle.
REQ-014 has_dat  out  NCH  per-channel flag, item count nonzero.
REQ-015 done  out  1  all channels drained for the current crossing.

Function
REQ-016 Each channel SHALL hold an AW-bit item counter and an AW-bit address counter.
REQ-017 On init, each item counter SHALL load its initial_count slice, each address counter SHALL clear to 0, and the FSM SHALL enter RUN, regardless of the current state.
REQ-018 FSM states SHALL be IDLE, RUN and DONE; IDLE is entered only from reset.
REQ-019 In RUN, when no init is present and every item counter is zero, the FSM SHALL enter DONE on the next edge.
REQ-020 A DONE-to-RUN transition SHALL occur only on init.
REQ-021 The selected channel SHALL be the lowest index whose item counter is nonzero (fixed priority, channel 0 highest).
REQ-022 grant = (state==RUN) & enable & ready & ~setup & ~init & any-nonzero, where any-nonzero means at least one item counter is nonzero.
REQ-023 On grant, only the selected channel's item counter SHALL decrement by 1, and its address counter SHALL increment by 1.
REQ-024 valid SHALL be registered: valid is high for exactly one cycle after each grant edge, otherwise low.
REQ-025 addr and chan SHALL be registered on grant as the selected channel's pre-increment address and its index.
REQ-026 addr and chan SHALL hold their values when there is no grant.
REQ-027 Latency from grant to valid/addr/chan SHALL be one clock.
REQ-028 Throughput SHALL be one item per clock while grant conditions hold.
REQ-029 has_dat[i] SHALL be registered (item counter i != 0), one cycle behind the counter.
REQ-030 done SHALL be high exactly while the state is DONE.
REQ-031 Item counters SHALL never decrement below zero.
REQ-032 The address counter SHALL never wrap, because a count is at most 2^AW-1.
REQ-033 If init and a grant condition coincide, init SHALL win: no decrement, and valid is low next cycle.
REQ-034 If ready or enable drops mid-crossing, counters SHALL freeze and the next grant SHALL resume at the same channel and address.
REQ-035 An init with all counts zero SHALL produce RUN for one cycle, then DONE, with no valid.

Reset
REQ-036 While rst_n is low, all counters, addr, chan, valid, has_dat and done SHALL be 0, and the state SHALL be IDLE, immediately and without waiting for clk.
REQ-037 Reset asserted mid-crossing SHALL discard all pending items; after release the block waits in IDLE for init.
REQ-038 Release of rst_n SHALL be synchronised externally; the block SHALL need no extra release logic.

Verification (NCH=4, AW=6; edge 0 = the edge sampling init)
REQ-039 Counts {2,0,1,3} with enable=ready=1: valid on edges 1-6 with (chan,addr) = (0,0),(0,1),(2,0),(3,0),(3,1),(3,2); done high from edge 7; has_dat = 0000 from edge 7.
REQ-040 Same load, ready low on edges 3-4: valid gaps on those edges; the sequence then resumes at (2,0) with nothing skipped or duplicated; done high from edge 9.
REQ-041 setup held high for edges 1-3 after init: no valid until edge 4; order identical to the first scenario.
REQ-042 A second init at edge 3 with counts {0,1,0,0}: no valid at edge 3; valid at edge 4 with (1,0); done from edge 5.
REQ-043 rst_n pulsed low between edges 2 and 3: valid, done and has_dat drop to 0 immediately; no valid until a new init is applied.
REQ-044 Counts all 63 on channel 0 only: 63 consecutive valids with addr 0..62, no wrap, and done on the following edge.

Source files
------------

// File: rtl/prio_readout_n_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_readout_n_if : read-out bus (ready/valid/addr/chan)           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface prio_readout_n_if #(
    parameter int NCH = 4,
    parameter int AW  = 6
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           ready;
    logic           valid;
    logic [AW-1:0]  addr;
    logic [CHW-1:0] chan;

    modport master (input ready, output valid, addr, chan);
    modport slave  (output ready, input valid, addr, chan);
endinterface
`default_nettype wire

// File: rtl/prio_readout_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_readout_n : fixed-priority multi-channel memory read-out      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module prio_readout_n #(
    parameter int NCH = 4,
    parameter int AW  = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [NCH*AW-1:0] initial_count,
    input  wire logic              init,
    input  wire logic              setup,
    input  wire logic              enable,
    output logic      [NCH-1:0]    has_dat,
    output logic                   done,
    prio_readout_n_if.master       rd
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_valid;
    logic [AW-1:0]            r_addr;
    logic [CHW-1:0]           r_chan;
    logic [NCH-1:0]           r_has_dat;
    logic                     r_done;

    logic [NCH-1:0][AW-1:0]   w_adr;
    logic [NCH-1:0]           w_nz;
    logic                     w_any;
    logic                     w_grant;
    logic [CHW-1:0]           w_sel;
    logic [AW-1:0]            w_sel_addr;

    // Per-channel item and address counters; only the selected channel moves.
    generate
        for (genvar g = 0; g < NCH; g++) begin : g_chan
            logic [AW-1:0] r_cnt;
            logic [AW-1:0] r_adr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_adr <= '0;
                end else if (init) begin
                    r_cnt <= initial_count[g*AW +: AW];
                    r_adr <= '0;
                end else if (w_grant && (w_sel == CHW'(g))) begin
                    r_cnt <= r_cnt - AW'(1);
                    r_adr <= r_adr + AW'(1);
                end
            end

            assign w_nz[g]  = (r_cnt != '0);
            assign w_adr[g] = r_adr;
        end
    endgenerate

    // Lowest nonzero channel wins; scanning downward leaves the lowest last.
    always_comb begin
        w_sel      = '0;
        w_sel_addr = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_nz[i]) begin
                w_sel      = CHW'(i);
                w_sel_addr = w_adr[i];
            end
        end
    end

    assign w_any   = |w_nz;
    assign w_grant = (r_state == RUN) & enable & rd.ready & ~setup & ~init & w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_chan    <= '0;
            r_has_dat <= '0;
            r_done    <= 1'b0;
        end else begin
            r_valid   <= w_grant;
            r_has_dat <= w_nz;
            if (w_grant) begin
                r_addr <= w_sel_addr;
                r_chan <= w_sel;
            end
            if (init) begin
                r_state <= RUN;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (!w_any) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE:    r_done <= 1'b1;
                    default: r_done <= 1'b0;
                endcase
            end
        end
    end

    assign rd.valid = r_valid;
    assign rd.addr  = r_addr;
    assign rd.chan  = r_chan;
    assign has_dat  = r_has_dat;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prio_readout_n.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_prio_readout_n : scoreboard bench for prio_readout_n            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_prio_readout_n;
    localparam int NCH = 4;
    localparam int AW  = 6;

    logic              clk;
    logic              rst_n;
    logic [NCH*AW-1:0] initial_count;
    logic              init;
    logic              setup;
    logic              enable;
    logic [NCH-1:0]    has_dat;
    logic              done;

    int n_checks;
    int n_errors;
    int q[$];

    prio_readout_n_if #(.NCH(NCH), .AW(AW)) bus ();

    prio_readout_n #(.NCH(NCH), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .initial_count (initial_count),
        .init          (init),
        .setup         (setup),
        .enable        (enable),
        .has_dat       (has_dat),
        .done          (done),
        .rd            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NCH-1:0] mask(input logic [NCH*AW-1:0] c);
        logic [NCH-1:0] m;
        for (int i = 0; i < NCH; i++) m[i] = (c[i*AW +: AW] != '0);
        return m;
    endfunction

    // Expected read order: channels drain completely in ascending index order.
    task automatic push_items(input logic [NCH*AW-1:0] c);
        for (int ch = 0; ch < NCH; ch++)
            for (int k = 0; k < int'(c[ch*AW +: AW]); k++)
                q.push_back((ch << AW) | k);
    endtask

    task automatic run(input logic [NCH*AW-1:0] counts, input int lo_a, input int lo_b,
                       input bit drop_en, input int setup_last, input int nedges,
                       input int exp_first, input int exp_done, input int reinit_edge,
                       input logic [NCH*AW-1:0] counts2);
        int first;
        int done_at;
        int e_item;
        first   = -1;
        done_at = -1;
        q.delete();
        push_items(counts);
        initial_count = counts;
        init = 1'b1; enable = 1'b1; bus.ready = 1'b1; setup = 1'b0;
        step();
        for (int e = 1; e <= nedges; e++) begin
            bus.ready = drop_en ? 1'b1 : !(e >= lo_a && e <= lo_b);
            enable    = drop_en ? !(e >= lo_a && e <= lo_b) : 1'b1;
            setup     = (e <= setup_last);
            if (e == reinit_edge) begin
                init = 1'b1;
                initial_count = counts2;
                q.delete();
                push_items(counts2);
            end else begin
                init = 1'b0;
            end
            step();
            if (e == 1) check("has_dat_load", has_dat, mask(counts));
            if (!bus.ready || !enable || setup || init) check("no_grant_valid", bus.valid, 0);
            if (bus.valid) begin
                if (first < 0) first = e;
                if (q.size() == 0) begin
                    check("sb_extra", bus.valid, 0);
                end else begin
                    e_item = q.pop_front();
                    check("sb_chan", bus.chan, e_item >> AW);
                    check("sb_addr", bus.addr, e_item & ((1 << AW) - 1));
                end
            end
            if (done && done_at < 0) done_at = e;
            check("done_level", done, (e >= exp_done) ? 1 : 0);
        end
        init = 1'b0;
        check("first_valid", first, exp_first);
        check("done_edge", done_at, exp_done);
        check("sb_drained", q.size(), 0);
        check("has_dat_end", has_dat, 0);
    endtask

    localparam logic [NCH*AW-1:0] C_A    = {6'd3, 6'd1, 6'd0, 6'd2};
    localparam logic [NCH*AW-1:0] C_B    = {6'd0, 6'd0, 6'd1, 6'd0};
    localparam logic [NCH*AW-1:0] C_Z    = '0;
    localparam logic [NCH*AW-1:0] C_FULL = {6'd0, 6'd0, 6'd0, 6'd63};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        initial_count = '0;
        init = 1'b0; setup = 1'b0; enable = 1'b0; bus.ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid",   bus.valid, 0);
        check("rst_done",    done, 0);
        check("rst_has_dat", has_dat, 0);
        check("rst_addr",    bus.addr, 0);
        check("rst_chan",    bus.chan, 0);
        step(); step();
        rst_n = 1'b1;
        enable = 1'b1; bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", bus.valid, 0);
            check("idle_done",  done, 0);
        end

        run(C_A,    0, -1, 1'b0, 0, 10,  1,  7, -1, C_Z);
        run(C_A,    3,  4, 1'b0, 0, 12,  1,  9, -1, C_Z);
        run(C_A,    0, -1, 1'b0, 3, 12,  4, 10, -1, C_Z);
        run(C_A,    0, -1, 1'b0, 0,  8,  1,  5,  3, C_B);
        run(C_Z,    0, -1, 1'b0, 0,  4, -1,  1, -1, C_Z);
        run(C_FULL, 0, -1, 1'b0, 0, 66,  1, 64, -1, C_Z);
        run(C_A,    2,  5, 1'b1, 0, 13,  1, 11, -1, C_Z);

        // Reset while in DONE clears done without a clock edge.
        check("pre_rst_done", done, 1);
        rst_n = 1'b0;
        #1;
        check("rst_in_done", done, 0);
        step();
        rst_n = 1'b1;

        // Reset mid-crossing discards pending items.
        initial_count = C_A;
        init = 1'b1; enable = 1'b1; bus.ready = 1'b1; setup = 1'b0;
        step();
        init = 1'b0;
        step(); step();
        check("pre_rst_valid", bus.valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",   bus.valid, 0);
        check("mid_rst_has_dat", has_dat, 0);
        check("mid_rst_addr",    bus.addr, 0);
        check("mid_rst_done",    done, 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_valid", bus.valid, 0);
            check("post_rst_done",  done, 0);
        end

        run(C_A, 0, -1, 1'b0, 0, 10, 1, 7, -1, C_Z);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
